mem_bus_arbiter: RTL and testbench

//  Arbitrates the single external memory bus between the write buffer, the data-side cache
//  and the instruction-side cache. It replaces the fixed-priority memory-system controller.
//  It drives the one-hot grants and the 2-bit select for the memadr/membyteen/memrwb muxes.
//  It adds write-burst starvation control, a post-write bus turnaround cycle and a

---
 rtl/mem_bus_arbiter.sv | 77 +++++++
 tb/tb_mem_bus_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants the external memory bus to the write buffer, dcache or icache with WB-burst limiting, turnaround and watchdog
module mem_bus_arbiter #(
  parameter int WBBURST    = 4,
  parameter int SW         = 3,
  parameter int TIMEOUT    = 255,
  parameter int TW         = 8,
  parameter int TURNAROUND = 1
) (
  input  logic       ph1,
  input  logic       ph2,
  input  logic       reset,
  input  logic       wbmemen,
  input  logic       dmemen,
  input  logic       dmemrwb,
  input  logic       imemen,
  input  logic       imemrwb,
  input  logic       swc,
  input  logic       memdone,
  output logic [1:0] state,
  output logic       wbon,
  output logic       don,
  output logic       ion,
  output logic       memen,
  output logic       memtimeout
);
  typedef enum logic [2:0] {S_IDLE, S_WB, S_D, S_I, S_TURN} st_t;
  st_t r_st, w_nx, w_rsel;
  logic [SW-1:0] r_sk, w_sk;
  logic [TW-1:0] r_wd;
  logic w_dreq, w_ireq, w_rd, w_gnt, w_to, w_unused;
  assign w_unused = ph2;
  assign w_dreq = dmemen & dmemrwb;
  assign w_ireq = imemen & imemrwb;
  assign w_rd = w_dreq | w_ireq;
  assign w_rsel = swc ? (w_ireq ? S_I : S_D) : (w_dreq ? S_D : S_I);
  assign w_gnt = (r_st == S_WB) | (r_st == S_D) | (r_st == S_I);
  // memdone in the final watchdog cycle takes precedence over the abort
  assign w_to = w_gnt & (r_wd == TW'(TIMEOUT - 1)) & ~memdone;
  always_comb begin
    w_nx = r_st;
    w_sk = r_sk;
    if (r_st == S_IDLE) begin
      if (wbmemen && !(w_rd && r_sk == SW'(WBBURST))) begin
        w_nx = S_WB;
        w_sk = !w_rd ? '0 : (&r_sk) ? r_sk : r_sk + SW'(1);
      end else begin
        w_nx = w_rd ? w_rsel : S_IDLE;
        w_sk = '0;
      end
    end else if (r_st == S_TURN) w_nx = S_IDLE;
    else if (memdone) w_nx = (r_st == S_WB && TURNAROUND == 1) ? S_TURN : S_IDLE;
    else if (w_to) w_nx = S_IDLE;
  end
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_st       <= S_IDLE;
      r_sk       <= '0;
      r_wd       <= '0;
      state      <= 2'b00;
      wbon       <= 1'b0;
      don        <= 1'b0;
      ion        <= 1'b0;
      memen      <= 1'b0;
      memtimeout <= 1'b0;
    end else begin
      r_st       <= w_nx;
      r_sk       <= w_sk;
      r_wd       <= (w_gnt && w_nx == r_st) ? ((&r_wd) ? r_wd : r_wd + TW'(1)) : '0;
      state      <= w_nx == S_WB ? 2'b01 : w_nx == S_D ? 2'b10 : w_nx == S_I ? 2'b11 : 2'b00;
      wbon       <= w_nx == S_WB;
      don        <= w_nx == S_D;
      ion        <= w_nx == S_I;
      memen      <= (w_nx == S_WB) | (w_nx == S_D) | (w_nx == S_I);
      memtimeout <= w_to;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench checking grant order, latency, gaps, burst limit and watchdog
module tb_mem_bus_arbiter;
  logic ph1 = 0, ph2, reset = 1;
  logic wbmemen = 0, dmemen = 0, dmemrwb = 0, imemen = 0, imemrwb = 0, swc = 0, memdone = 0;
  logic [1:0] state;
  logic wbon, don, ion, memen, memtimeout;
  int checks = 0, errors = 0;
  logic [1:0] q[$];
  logic prev = 0;
  always #5 ph1 = ~ph1;
  assign ph2 = ~ph1;
  mem_bus_arbiter dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .wbmemen(wbmemen), .dmemen(dmemen),
    .dmemrwb(dmemrwb), .imemen(imemen), .imemrwb(imemrwb), .swc(swc), .memdone(memdone),
    .state(state), .wbon(wbon), .don(don), .ion(ion), .memen(memen), .memtimeout(memtimeout)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge ph1);
  endtask
  task automatic wait_grant(input string tag, input int lat);
    int n = 0;
    do begin cyc(); n++; end while (!memen && n < 20);
    chk({tag, "_lat"}, memen ? n : -1, lat);
  endtask
  task automatic done;
    memdone = 1;
    cyc();
    memdone = 0;
    chk("drop", memen, 0);
  endtask
  always @(negedge ph1) begin
    if (memen && !prev) begin
      if (q.size() == 0) chk("grant_extra", state, 0);
      else begin
        logic [1:0] e;
        e = q.pop_front();
        chk("grant", state, e);
        chk("onehot", {wbon, don, ion}, e == 2'b01 ? 3'b100 : e == 2'b10 ? 3'b010 : 3'b001);
      end
    end
    prev = memen;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) cyc();
    chk("rst_state", state, 0);
    chk("rst_memen", memen, 0);
    reset = 0;
    cyc();
    q.push_back(2'b01);
    wbmemen = 1;
    wait_grant("t1", 1);
    reset = 1;
    cyc();
    reset = 0;
    wbmemen = 0;
    chk("t1_state", state, 0);
    chk("t1_memen", memen, 0);
    chk("t1_wbon", wbon, 0);
    chk("t1_to", memtimeout, 0);
    cyc();
    chk("t1_idle", memen, 0);
    imemen = 1;
    repeat (5) cyc();
    chk("wr_ignored", memen, 0);
    imemen = 0;
    imemrwb = 1;
    dmemrwb = 1;
    q.push_back(2'b01); q.push_back(2'b10); q.push_back(2'b11);
    wbmemen = 1; dmemen = 1; imemen = 1;
    wait_grant("t2wb", 1);
    wbmemen = 0;
    done();
    chk("turn_state", state, 0);
    wait_grant("t2d", 2);
    dmemen = 0;
    done();
    wait_grant("t2i", 1);
    imemen = 0;
    done();
    cyc();
    repeat (4) q.push_back(2'b01);
    q.push_back(2'b10); q.push_back(2'b01);
    wbmemen = 1; dmemen = 1;
    wait_grant("t3wb0", 1);
    done();
    for (int i = 0; i < 3; i++) begin
      wait_grant("t3wb", 2);
      done();
    end
    wait_grant("t3d", 2);
    done();
    wait_grant("t3wb_after", 1);
    wbmemen = 0; dmemen = 0;
    done();
    repeat (2) cyc();
    q.push_back(2'b11); q.push_back(2'b10); q.push_back(2'b11);
    swc = 1; imemen = 1; dmemen = 1;
    wait_grant("t4i", 1);
    swc = 0;
    repeat (3) begin cyc(); chk("hold_i", ion, 1); end
    done();
    wait_grant("t4d", 1);
    dmemen = 0;
    done();
    wait_grant("t4i2", 1);
    imemen = 0;
    done();
    cyc();
    q.push_back(2'b10);
    dmemen = 1;
    wait_grant("t5", 1);
    dmemen = 0;
    n = 1;
    while (memen && n < 400) begin cyc(); if (memen) n++; end
    chk("t5_len", n, 255);
    chk("t5_pulse", memtimeout, 1);
    chk("t5_state", state, 0);
    cyc();
    chk("t5_pulse_end", memtimeout, 0);
    q.push_back(2'b10);
    dmemen = 1;
    wait_grant("t6", 1);
    dmemen = 0;
    repeat (254) cyc();
    chk("t6_held", memen, 1);
    done();
    chk("t6_to", memtimeout, 0);
    cyc();
    chk("t6_to2", memtimeout, 0);
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
